// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one combinational 32-bit ALU
// between N_REQ requesters. Each accepted request is registered onto the ALU
// inputs, the result is captured one cycle later and returned on a single
// response channel tagged with the requester index.
// Optional feature: define ALU_ARB_ILLEGAL_OP_EN to flag ops > 6 via rsp_err
// instead of forwarding them to the ALU.
module alu_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [5*N_REQ-1:0]    req_op,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [4:0]            alu_op,
    input  logic [31:0]           alu_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_found;
    logic                accept;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [OP_W-1:0]     sel_op;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            int unsigned cand;
            cand = 32'(last_grant) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!grant_found && req_valid[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                sel_a  = req_a[i*DATA_W +: DATA_W];
                sel_b  = req_b[i*DATA_W +: DATA_W];
                sel_op = req_op[i*OP_W +: OP_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and combinational grant strobe
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready = N_REQ'(1) << grant_idx;
                    accept    = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    localparam logic [OP_W-1:0] OP_MAX = OP_W'(6);

    logic sel_illegal;
    logic illegal_q;

    assign sel_illegal = (sel_op > OP_MAX);

    // Datapath: ALU operand capture, result capture, response flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            last_grant <= ID_W'(N_REQ - 1);
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b0;
            illegal_q  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant_idx;
                rsp_id     <= grant_idx;
                illegal_q  <= sel_illegal;
                // Illegal ops leave the ALU inputs untouched
                if (!sel_illegal) begin
                    alu_a  <= sel_a;
                    alu_b  <= sel_b;
                    alu_op <= sel_op;
                end
            end
            if (state_q == EXEC) begin
                rsp_data  <= illegal_q ? '0 : alu_out;
                rsp_err   <= illegal_q;
                rsp_valid <= 1'b1;
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            busy <= (state_d != IDLE);
        end
    end
`else
    assign rsp_err = 1'b0;

    // Datapath: ALU operand capture, result capture, response flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            last_grant <= ID_W'(N_REQ - 1);
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant_idx;
                rsp_id     <= grant_idx;
                alu_a      <= sel_a;
                alu_b      <= sel_b;
                alu_op     <= sel_op;
            end
            if (state_q == EXEC) begin
                rsp_data  <= alu_out;
                rsp_valid <= 1'b1;
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            busy <= (state_d != IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned IW = 1;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [5*N-1:0]    req_op;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [4:0]        alu_op;
    logic [31:0]       alu_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [IW-1:0]     rsp_id;
    logic              rsp_err;
    logic              busy;

    logic [31:0] ra  [N];
    logic [31:0] rb  [N];
    logic [4:0]  rop [N];

    int n_checks;
    int n_errors;

    // Reference model state
    int          ptr;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [4:0]  exp_op;
    logic [31:0] exp_data;
    int          exp_id;
    logic        exp_err;

    alu_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: 0 and, 1 add, 2 sub, 3 or, 4 xor, 5 slt, 6 nor
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
        case (op)
            5'd0:    return a & b;
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return {31'd0, ($signed(a) < $signed(b))};
            5'd6:    return ~(a | b);
            default: return a ^ b ^ 32'(op);
        endcase
    endfunction

    assign alu_out = alu_f(alu_a, alu_b, alu_op);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = ra[i];
            req_b[i*32 +: 32] = rb[i];
            req_op[i*5 +: 5]  = rop[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int predict_grant(input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] one_hot(input int g);
        logic [N-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        ptr      = N - 1;
        exp_a    = '0;
        exp_b    = '0;
        exp_op   = '0;
        exp_data = '0;
        exp_id   = 0;
        exp_err  = 1'b0;
    endtask

    task automatic note_accept(input int g);
        bit illegal;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        illegal = (rop[g] > 5'd6);
`else
        illegal = 1'b0;
`endif
        ptr    = g;
        exp_id = g;
        if (!illegal) begin
            exp_a  = ra[g];
            exp_b  = rb[g];
            exp_op = rop[g];
        end
        exp_data = illegal ? 32'd0 : alu_f(ra[g], rb[g], rop[g]);
        exp_err  = illegal;
    endtask

    function automatic logic [4:0] rand_op();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(7, 31));
        return 5'($urandom_range(0, 6));
    endfunction

    task automatic scramble();
        req_valid = N'($urandom);
        for (int i = 0; i < N; i++) begin
            ra[i]  = $urandom;
            rb[i]  = $urandom;
            rop[i] = rand_op();
        end
    endtask

    task automatic check_rsp(input string tag);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    // One full transaction from an idle cycle; stall = cycles of rsp_ready low in RESP
    task automatic do_txn(input logic [N-1:0] mask, input int stall,
                          input bit has_exp, input logic [31:0] exp_override);
        int g;
        req_valid = mask;
        rsp_ready = 1'b0;
        #4;
        if (mask == '0) begin
            check("idle_ready", 32'(req_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_alu_op", 32'(alu_op), 32'(exp_op));
            tick();
            return;
        end
        g = predict_grant(mask);
        check("grant", 32'(req_ready), 32'(one_hot(g)));
        check("pre_busy", 32'(busy), 32'd0);
        check("pre_rsp_valid", 32'(rsp_valid), 32'd0);
        note_accept(g);
        if (has_exp) exp_data = exp_override;
        tick();
        scramble();
        #4;
        check("exec_ready", 32'(req_ready), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_alu_a", alu_a, exp_a);
        check("exec_alu_b", alu_b, exp_b);
        check("exec_alu_op", 32'(alu_op), 32'(exp_op));
        tick();
        for (int s = 0; s < stall; s++) begin
            scramble();
            rsp_ready = 1'b0;
            #4;
            check_rsp("stall");
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            tick();
        end
        scramble();
        rsp_ready = 1'b1;
        #4;
        check_rsp("resp");
        tick();
        rsp_ready = 1'b0;
        req_valid = '0;
        #4;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0; rb[i] = '0; rop[i] = '0;
        end
        model_reset();
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed arithmetic cases
        ra[0] = 32'd5; rb[0] = 32'd7; rop[0] = 5'd1;
        do_txn(2'b01, 0, 1'b1, 32'd12);
        ra[1] = 32'd3; rb[1] = 32'd5; rop[1] = 5'd2;
        do_txn(2'b10, 0, 1'b1, 32'hFFFF_FFFE);
        ra[1] = 32'hF0F0_F0F0; rb[1] = 32'h0F0F_0000; rop[1] = 5'd6;
        do_txn(2'b10, 0, 1'b1, 32'h0000_0F0F);

        // Both requesters held valid: grants 0,1,0,1 every 3 cycles
        for (int i = 0; i < N; i++) begin
            ra[i] = 32'(i + 10); rb[i] = 32'd3; rop[i] = 5'd1;
        end
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #4;
            if (cyc % 3 == 0) begin
                check("rr_ready", 32'(req_ready), ((cyc / 3) % 2 == 0) ? 32'd1 : 32'd2);
                note_accept(predict_grant(req_valid));
            end else begin
                check("rr_ready_low", 32'(req_ready), 32'd0);
            end
            if (cyc % 3 == 2) begin
                check_rsp("rr_rsp");
                check("rr_id_seq", 32'(rsp_id), 32'((cyc / 3) % 2));
            end else begin
                check("rr_rsp_low", 32'(rsp_valid), 32'd0);
            end
            tick();
            ra[0] = $urandom; ra[1] = $urandom;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();

        // Response back-pressure for 5 cycles
        ra[0] = 32'h1234_5678; rb[0] = 32'h0000_0008; rop[0] = 5'd4;
        do_txn(2'b01, 5, 1'b1, 32'h1234_5670);

        // Reset during EXEC drops the request and restarts the pointer
        ra[1] = 32'd100; rb[1] = 32'd1; rop[1] = 5'd1;
        req_valid = 2'b10;
        #4;
        check("pre_rst_grant", 32'(req_ready), 32'd2);
        tick();
        #2;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_alu_a", alu_a, 32'd0);
        check("midrst_alu_b", alu_b, 32'd0);
        check("midrst_alu_op", 32'(alu_op), 32'd0);
        check("midrst_rsp_data", rsp_data, 32'd0);
        check("midrst_rsp_id", 32'(rsp_id), 32'd0);
        check("midrst_rsp_err", 32'(rsp_err), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #4;
            check("postrst_no_rsp", 32'(rsp_valid), 32'd0);
            check("postrst_busy", 32'(busy), 32'd0);
            tick();
        end
        ra[0] = 32'd9; rb[0] = 32'd4; rop[0] = 5'd2;
        req_valid = 2'b11;
        #1;
        check("postrst_grant0", 32'(req_ready), 32'd1);
        do_txn(2'b11, 0, 1'b1, 32'd5);

        // Op above 6
        ra[1] = 32'd1; rb[1] = 32'd1; rop[1] = 5'd9;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        do_txn(2'b10, 1, 1'b1, 32'd0);
        check("illegal_err_seen", 32'(exp_err), 32'd1);
        check("illegal_alu_op_kept", 32'(alu_op), 32'd2);
`else
        do_txn(2'b10, 1, 1'b1, 32'd9);
        check("op9_alu_op", 32'(alu_op), 32'd9);
        check("op9_err", 32'(rsp_err), 32'd0);
`endif

        // Randomized transactions
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < N; i++) begin
                ra[i]  = $urandom;
                rb[i]  = $urandom;
                rop[i] = rand_op();
            end
            do_txn(N'($urandom), int'($urandom_range(0, 3)), 1'b0, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 32-bit ALU (op codes 0..6) between N_REQ requesters.
- Each requester hands over operands and op through a valid/ready handshake. The block registers them onto the ALU inputs, captures the ALU result one cycle later, and returns it on a single response channel tagged with the requester ID.
- Sits between the multi-cycle CPU control units (or test masters) and the shared ALU instance.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of rsp_id; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_a  input  32*N_REQ  operand A, requester i at bits [32i+31:32i].
- req_b  input  32*N_REQ  operand B, same packing.
- req_op  input  5*N_REQ  ALU op, requester i at bits [5i+4:5i].
- alu_a  output  32  registered operand A to the ALU.
- alu_b  output  32  registered operand B to the ALU.
- alu_op  output  5  registered op to the ALU.
- alu_out  input  32  ALU result, combinational from alu_a/alu_b/alu_op.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_data  output  32  captured result.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_err  output  1  illegal-op flag (see Optional Feature).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; alu_a=0, alu_b=0, alu_op=0; rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0; req_ready=0; busy=0; last_grant=N_REQ-1, so requester 0 wins first.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching from last_grant+1 upward with wrap modulo N_REQ.
  - req_ready[g]=1 combinationally; all other bits 0. req_ready is 0 in every other state.
  - On a cycle with any req_valid: latch req_a/b/op[g] into alu_a/alu_b/alu_op, set rsp_id=g, set last_grant=g, go to EXEC.
  - No valid: stay in IDLE; ALU input registers hold their last values.
- EXEC (one cycle): rsp_data<=alu_out, rsp_err<=0, go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data, rsp_id and rsp_err stay stable until rsp_valid&rsp_ready.
  - On that handshake go to IDLE; rsp_valid drops the next cycle.
- Latency: request accepted at edge T; rsp_valid high from T+2. Minimum spacing between accepts is 3 cycles, achieved when rsp_ready is held high.
- A requester may deassert req_valid before it is granted. The block never latches from a requester whose valid is low.
- req_valid changing during EXEC or RESP has no effect.
- Reset mid-operation: any in-flight request is dropped, no response is produced, and the pointer returns to N_REQ-1.
- Arithmetic is done entirely by the ALU. The block passes 32-bit values unmodified and does no sign or width conversion.

Optional Feature:
- Macro: ALU_ARB_ILLEGAL_OP_EN.
- Defined:
  - A granted request with op > 6 is still accepted, but alu_a/alu_b/alu_op are not updated.
  - EXEC loads rsp_data=0 and rsp_err=1; timing is unchanged (rsp_valid at T+2).
- Not defined:
  - Every op is forwarded to the ALU unchanged and rsp_err is tied to 0.
  - The result of an op > 6 is whatever alu_out presents.

Test Plan:
- Requester 0 sends op=1, a=5, b=7 at cycle T, rsp_ready=1 -> req_ready[0]=1 at T; rsp_valid=1, rsp_data=12, rsp_id=0 at T+2; IDLE at T+3.
- Requester 1 sends op=2, a=3, b=5 -> rsp_data=0xFFFFFFFE, rsp_id=1. Then op=6, a=0xF0F0F0F0, b=0x0F0F0000 -> rsp_data=0x00000F0F.
- Both requesters hold req_valid=1 continuously for 4 transactions -> grant order 0,1,0,1; rsp_id sequence 0,1,0,1; accepts spaced exactly 3 cycles.
- rsp_ready held 0 for 5 cycles during RESP -> rsp_valid, rsp_data and rsp_id stay constant, req_ready stays 0, busy=1; rsp_ready=1 -> IDLE next cycle.
- rst_n pulsed low while in EXEC -> all outputs 0 immediately; no response; the next request with both valid is granted to requester 0.
- op=9, a=1, b=1:
  - With ALU_ARB_ILLEGAL_OP_EN defined -> rsp_err=1, rsp_data=0, alu_op keeps its previous value.
  - Without the macro -> alu_op=9 and rsp_err=0.
